// File: rtl/sram_stream_ctrl_pkg.sv
// sram_stream_ctrl_pkg: shared state encoding and default SRAM geometry
package sram_stream_ctrl_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH = 2 ** ADDR_W_DEF;
  typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, OUT} state_e;
endpackage

// File: rtl/sram_stream_ctrl.sv
// sram_stream_ctrl: loads a byte stream into a synchronous SRAM and dumps it back in address order
module sram_stream_ctrl
  import sram_stream_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              dump_start,
  input  logic              clear,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_EN,
  input  logic [DATA_W-1:0] mem_out_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done
);
  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d, rptr_q, rptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, m_data_q, m_data_d;
  logic                en_q, en_d, m_valid_q, m_valid_d, done_q, done_d, last;
  // count only reaches 2**ADDR_W at its top bit, so that bit alone means full
  assign s_ready     = (state_q == IDLE) && !count_q[ADDR_W] && !dump_start;
  assign last        = (rptr_q + 1'b1) == count_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign mem_address = addr_q;
  assign mem_in_data = wdata_q;
  assign mem_EN      = en_q;
  assign count       = count_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rptr_d    = rptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    en_d      = 1'b0;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_start && count_q != '0) begin
          rptr_d  = '0;
          state_d = RD_ADDR;
        end else if (s_valid && s_ready) begin
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = s_data;
          en_d    = 1'b1;
          state_d = WRITE;
        end else if (clear) begin
          count_d = '0;
        end
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        state_d = IDLE;
      end
      RD_ADDR: begin
        addr_d  = rptr_q[ADDR_W-1:0];
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        m_data_d  = mem_out_data;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          rptr_d    = rptr_q + 1'b1;
          done_d    = last;
          state_d   = last ? IDLE : RD_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rptr_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      en_q      <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rptr_q    <= rptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      en_q      <= en_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
    end
  end
endmodule
